// File: rtl/mux_rr_16to1.sv
// Sixteen-channel round-robin multiplexer with valid/ready handshakes and one output register.
// Emits {o, sel} so a downstream demux can route each word back by its source index.
module mux_rr_16to1 #(
    parameter int unsigned width = 8,
    parameter int unsigned snum  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i0,
    input  logic [width-1:0] i1,
    input  logic [width-1:0] i2,
    input  logic [width-1:0] i3,
    input  logic [width-1:0] i4,
    input  logic [width-1:0] i5,
    input  logic [width-1:0] i6,
    input  logic [width-1:0] i7,
    input  logic [width-1:0] i8,
    input  logic [width-1:0] i9,
    input  logic [width-1:0] i10,
    input  logic [width-1:0] i11,
    input  logic [width-1:0] i12,
    input  logic [width-1:0] i13,
    input  logic [width-1:0] i14,
    input  logic [width-1:0] i15,
    input  logic [15:0]      v,
    output logic [15:0]      rdy,
    output logic [width-1:0] o,
    output logic [snum-1:0]  sel,
    output logic             o_valid,
    input  logic             o_ready
);

    localparam logic [snum-1:0] one = snum'(1);

    logic [width-1:0] din [16];
    logic [width-1:0] o_q;
    logic [snum-1:0]  sel_q;
    logic             o_valid_q;
    logic [snum-1:0]  ptr_q;

    logic [snum-1:0]  gnt;
    logic [snum-1:0]  idx;
    logic             found;
    logic             load;

    always_comb begin
        din[0]  = i0;
        din[1]  = i1;
        din[2]  = i2;
        din[3]  = i3;
        din[4]  = i4;
        din[5]  = i5;
        din[6]  = i6;
        din[7]  = i7;
        din[8]  = i8;
        din[9]  = i9;
        din[10] = i10;
        din[11] = i11;
        din[12] = i12;
        din[13] = i13;
        din[14] = i14;
        din[15] = i15;
    end

    // First valid channel scanning upward from ptr, wrapping through the index width.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int j = 0; j < 16; j++) begin
            idx = ptr_q + j[snum-1:0];
            if (!found && v[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign load = !o_valid_q || o_ready;

    always_comb begin
        rdy = '0;
        if (!rst && load && found) begin
            rdy[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q       <= '0;
            sel_q     <= '0;
            o_valid_q <= 1'b0;
            ptr_q     <= '0;
        end else if (load) begin
            if (found) begin
                o_q       <= din[gnt];
                sel_q     <= gnt;
                o_valid_q <= 1'b1;
                ptr_q     <= gnt + one;
            end else begin
                // Word consumed with nothing to replace it: o and sel keep their last values.
                o_valid_q <= 1'b0;
            end
        end
    end

    assign o       = o_q;
    assign sel     = sel_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_mux_rr_16to1.sv
// Scoreboard bench for mux_rr_16to1: directed scenarios followed by randomized traffic,
// checked against a rotate-and-search reference model.
module tb_mux_rr_16to1;

    logic        clk;
    logic        rst;
    logic [7:0]  din [16];
    logic [15:0] v;
    logic [15:0] rdy;
    logic [7:0]  o;
    logic [3:0]  sel;
    logic        o_valid;
    logic        o_ready;

    int checks = 0;
    int errors = 0;

    // Reference state: rotation start, and the word the output register should hold.
    int          m_ptr;
    logic        m_valid;
    logic [7:0]  m_o;
    logic [3:0]  m_sel;
    logic [15:0] last_acc;
    logic [11:0] exp_q [$];

    mux_rr_16to1 #(.width(8), .snum(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i0      (din[0]),
        .i1      (din[1]),
        .i2      (din[2]),
        .i3      (din[3]),
        .i4      (din[4]),
        .i5      (din[5]),
        .i6      (din[6]),
        .i7      (din[7]),
        .i8      (din[8]),
        .i9      (din[9]),
        .i10     (din[10]),
        .i11     (din[11]),
        .i12     (din[12]),
        .i13     (din[13]),
        .i14     (din[14]),
        .i15     (din[15]),
        .v       (v),
        .rdy     (rdy),
        .o       (o),
        .sel     (sel),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_grant(input logic [15:0] vv, input int p);
        for (int k = 0; k < 16; k++) begin
            int c = (p + k) % 16;
            if (vv[c]) return c;
        end
        return -1;
    endfunction

    // One clock: compare mid-cycle, advance the model at the edge, return just after it.
    task automatic step();
        int          g;
        logic        ld;
        logic [15:0] er;
        @(negedge clk);
        g  = ref_grant(v, m_ptr);
        ld = !m_valid || o_ready;
        er = (ld && g >= 0) ? (16'h1 << g) : 16'h0;
        check("rdy", rdy, er);
        check("o_valid", o_valid, m_valid);
        check("o", o, m_o);
        check("sel", sel, m_sel);
        last_acc = er;
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_o     = din[g];
                m_sel   = g[3:0];
                m_valid = 1'b1;
                m_ptr   = (g + 1) % 16;
                exp_q.push_back({din[g], g[3:0]});
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #1;
        rst = 1'b1;
        #1;
        check("rst o", o, 0);
        check("rst sel", sel, 0);
        check("rst o_valid", o_valid, 0);
        check("rst rdy", rdy, 0);
        m_ptr   = 0;
        m_valid = 1'b0;
        m_o     = '0;
        m_sel   = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst rdy held", rdy, 0);
        rst = 1'b0;
    endtask

    // Monitor: every word consumed downstream must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                check("scoreboard underflow", {o, sel}, 12'hfff);
            end else begin
                check("scoreboard word", {o, sel}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst      = 1'b1;
        v        = 16'hffff;
        o_ready  = 1'b1;
        last_acc = '0;
        m_ptr    = 0;
        m_valid  = 1'b0;
        m_o      = '0;
        m_sel    = '0;
        for (int k = 0; k < 16; k++) din[k] = '0;

        // Power-on reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("por o", o, 0);
        check("por sel", sel, 0);
        check("por o_valid", o_valid, 0);
        check("por rdy", rdy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single channel.
        v       = 16'h0020;
        din[5]  = 8'hf0;
        step();
        check("single o", o, 8'hf0);
        check("single sel", sel, 4'd5);
        check("single o_valid", o_valid, 1);

        // Reset while a word is held.
        v = 16'hffff;
        do_reset();

        // Round-robin from channel 0 with all channels valid.
        for (int k = 0; k < 16; k++) din[k] = {k[3:0], 4'h0};
        repeat (17) step();
        check("rr last sel", sel, 0);
        check("rr last o", o, 8'h00);

        // Wrap and skip: after a grant to 13, v=0009 goes to 0 then 3.
        v = 16'h2000;
        step();
        v = 16'h0009;
        step();
        check("wrap sel0", sel, 0);
        step();
        check("wrap sel3", sel, 3);

        // Back-pressure on a held A0 word.
        v = 16'h0400;
        step();
        check("bp load o", o, 8'ha0);
        v       = 16'hffff;
        o_ready = 1'b0;
        repeat (5) step();
        check("bp hold o", o, 8'ha0);
        check("bp hold sel", sel, 10);
        o_ready = 1'b1;
        step();
        check("bp resume o_valid", o_valid, 1);
        check("bp resume sel", sel, 11);

        // Drain.
        v = 16'h0000;
        step();
        step();
        check("drain o_valid", o_valid, 0);
        check("drain o", o, 8'hb0);
        check("drain sel", sel, 11);

        // Randomized traffic; sources hold data while valid and unaccepted.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            for (int k = 0; k < 16; k++) begin
                if (!v[k] || last_acc[k]) din[k] = 8'($urandom);
            end
            case ($urandom_range(0, 2))
                0:       v = 16'($urandom);
                1:       v = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: v = 16'hffff;
            endcase
            o_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        v       = 16'h0000;
        o_ready = 1'b1;
        repeat (3) step();
        check("queue empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_16to1.md
Name: mux_rr_16to1

Overview:
- Sixteen-channel, round-robin, registered multiplexer with valid/ready handshake on every channel and on the output.
- It is the collection end of the 1-to-16 demux path. It forwards one word per cycle and emits {o, sel} so that a downstream demux can route the word back by index.
- One output register stage. Full throughput: one word per clock when the output is not stalled.

Parameters:
- width, 8, data width of every channel and of the output.
- snum, 4, select/index width. The channel count is 2**snum and is fixed at 16 for this block.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i0..i15  input  width each  channel data.
- v  input  16  per-channel valid. Bit k qualifies ik.
- rdy  output  16  per-channel ready. Bit k high means ik is accepted this cycle. Combinational.
- o  output  width  registered output data.
- sel  output  snum  registered index of the channel that produced o.
- o_valid  output  1  o and sel hold an unconsumed word.
- o_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset, asynchronous, any time: o=0, sel=0, o_valid=0, round-robin pointer ptr=0. While rst is high, rdy=0.
- A reset asserted mid-transfer discards the held word. No channel sees a handshake in the cycle the reset is sampled.
- load = !o_valid || o_ready. The output register can take a new word this cycle.
- Arbitration, combinational:
  - Scan the channels in the order ptr, ptr+1, ..., ptr+15, all mod 16.
  - The grant g is the first k with v[k]=1.
  - If no v bit is set, there is no grant.
- rdy[k] = load && grant exists && (k == g). At most one rdy bit is high per cycle.
- Transfer on a clock edge with load and a grant:
  - o <= ig, sel <= g, o_valid <= 1.
  - ptr <= g+1 mod 16. Index 15 wraps to 0.
- Output consumed with no grant (o_ready=1 and v=0): o_valid <= 0. o and sel keep their last values. ptr is unchanged.
- Stall (o_valid=1, o_ready=0): o, sel, o_valid and ptr all hold. rdy=0. Source data must be held by each source while its v is asserted.
- Simultaneous consume and load (o_valid=1, o_ready=1, grant present): the new word replaces the old one in the same edge. o_valid stays 1. This gives zero-bubble throughput.
- Latency: an input accepted at edge N appears on o/sel/o_valid after edge N, one cycle.
- Fairness: with every channel permanently valid and o_ready=1, the grant sequence is 0,1,2,...,15,0,...
  - No channel waits more than 15 grants once it is valid.
- ptr advances only on a grant. Idle cycles do not rotate it.
- v bits that drop without a handshake are legal. The scan simply skips them.
- Width rules: no arithmetic on data. The ptr increment is snum bits wide and wraps naturally.

Test Plan:
- Reset: assert rst mid-run with o_valid=1 -> o=0, sel=0, o_valid=0 asynchronously, before the next clock. rdy=0 while rst is high. The first grant after release comes from channel 0 when v=16'hFFFF.
- Single channel: v=16'h0020, i5=8'hF0, o_ready=1 -> rdy=16'h0020 for one cycle, then o=8'hF0, sel=4'b0101, o_valid=1. ptr becomes 6.
- Round-robin: v=16'hFFFF, ik={k[3:0],4'h0}, o_ready=1 for 17 cycles -> sel sequence 0..15,0. o tracks 8'h00,8'h10,...,8'hF0,8'h00. o_valid stays 1 after the first word.
- Wrap and skip: ptr=14 after a grant to 13, v=16'h0009 -> grants go to channel 0, then channel 3. Channels 14 and 15 are skipped.
- Back-pressure: o_valid=1, o=8'hA0, o_ready=0 for 5 cycles with v=16'hFFFF -> o, sel and ptr are unchanged and rdy=0. On the first cycle o_ready=1, a new word loads in the same edge and o_valid stays 1.
- Drain: the last word is held and v=0, o_ready=1 -> o_valid falls next edge. o and sel keep their last values. rdy=0.
